// File: rtl/ro_sweep_scheduler.sv
// Ring-oscillator sweep sequencer: for each oscillator it selects, clears, gates for a
// fixed window, drains and then offers the frozen count on a valid/ready result port.
module ro_sweep_scheduler #(
  parameter int N_RO   = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 4,
  parameter int WINDOW = 100,
  parameter int DRAIN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic [SEL_W-1:0] ro_sel,
  output logic             ro_en,
  output logic             cnt_clr,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic [SEL_W-1:0] res_id,
  output logic             busy,
  output logic             sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_WINDOW, S_DRAIN, S_OUTPUT
  } state_t;

  localparam int MAX_LEN = (WINDOW > SETTLE) ? ((WINDOW > DRAIN) ? WINDOW : DRAIN)
                                             : ((SETTLE > DRAIN) ? SETTLE : DRAIN);
  localparam int TMR_W = $clog2(MAX_LEN + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(DRAIN - 1);
  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(N_RO - 1);

  state_t           r_state;
  state_t           w_next;
  logic [TMR_W-1:0] r_tmr;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_res_data;
  logic [SEL_W-1:0] r_res_id;
  logic             r_sweep_done;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == S_OUTPUT) && res_ready;
  assign w_last   = (r_idx == LAST_IDX);

  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_SETTLE;
      S_SETTLE: if (r_tmr == SETTLE_LAST) w_next = S_WINDOW;
      S_WINDOW: if (r_tmr == WINDOW_LAST) w_next = S_DRAIN;
      S_DRAIN:  if (r_tmr == DRAIN_LAST) w_next = S_OUTPUT;
      S_OUTPUT: if (res_ready) w_next = (!w_last || continuous) ? S_CLEAR : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // abort outranks start, the handshake and every timed transition
    if (abort) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr        <= '0;
      r_idx        <= '0;
      r_res_data   <= '0;
      r_res_id     <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_tmr        <= (w_next != r_state) ? '0 : r_tmr + TMR_W'(1);
      r_sweep_done <= w_accept && w_last && !abort;

      if (abort) begin
        r_idx <= '0;
      end else if (r_state == S_IDLE && start) begin
        r_idx <= '0;
      end else if (w_accept) begin
        // after the last oscillator idx holds unless a continuous restart needs 0
        if (!w_last)        r_idx <= r_idx + SEL_W'(1);
        else if (continuous) r_idx <= '0;
      end

      if (r_state == S_DRAIN && r_tmr == DRAIN_LAST) begin
        r_res_data <= cnt_value;
        r_res_id   <= r_idx;
      end
    end
  end

  always_comb begin
    ro_en     = 1'b0;
    cnt_clr   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE:   busy      = 1'b0;
      S_CLEAR:  cnt_clr   = 1'b1;
      S_WINDOW: ro_en     = 1'b1;
      S_OUTPUT: res_valid = 1'b1;
      default:  ;
    endcase
  end

  assign ro_sel     = r_idx;
  assign res_data   = r_res_data;
  assign res_id     = r_res_id;
  assign sweep_done = r_sweep_done;

endmodule
